ddr3_gearbox_ser: RTL and testbench
===================================

DDR3_GEARBOX_SER -- requirements
Module: ddr3_gearbox_ser

Interface
REQ-001 Parameter W, default 8: lane width in bits; legal range 1..32.
REQ-002 Parameter DIV, default 5: lanes per word, matching the divide-by-5 slow/fast clock ratio; legal range 2..8.
REQ-003 hclkin  input  1: fast clock; all logic on the rising edge.
REQ-004 resetn  input  1: synchronous, active-low reset.
REQ-005 calib  input  1: synchronous slot-realign request.
REQ-006 in_data  input  DIV*W: parallel word; lane k is bits [k*W+W-1 : k*W].
REQ-007 in_valid  input  1: in_data is valid.
REQ-008 in_ready  output  1: block can accept a word this cycle.
REQ-009 out_data  output  W: serial lane output.
REQ-010 out_valid  output  1: out_data carries a real lane.
REQ-011 word_start  output  1: out_data is lane 0 of a word.
REQ-012 phase  output  3: current lane slot index, 0..DIV-1.
REQ-013 gap_cnt  output  16: count of idle slots since the first accepted word; saturates.

Function
REQ-014 Storage SHALL be a holding register (hold, hold_full) and a shift register (shift, active).
REQ-015 phase SHALL count 0,1,...,DIV-1,0,... every cycle; the edge where phase==DIV-1 is the slot boundary.
REQ-016 in_ready SHALL equal !hold_full; a handshake is in_valid && in_ready on a rising edge.
REQ-017 A handshake on a non-boundary edge SHALL write hold and set hold_full.
REQ-018 At a boundary edge with hold_full=1, the block SHALL load shift<=hold, set active=1 and clear hold_full. A same-edge handshake is impossible because in_ready=0.
REQ-019 At a boundary edge with hold_full=0 and a handshake, the block SHALL bypass hold and load shift<=in_data with active=1; hold_full stays 0.
REQ-020 At a boundary edge with no word available, active SHALL clear to 0.
REQ-021 gap_cnt SHALL increment on that idle boundary only if a word has been accepted since reset, and SHALL saturate at 16'hFFFF.
REQ-022 Outputs:
- out_data = lane[phase] of shift when active=1, otherwise 0.
- out_valid = active.
- word_start = active && phase==0.
REQ-023 Outputs SHALL be driven only from registers; there SHALL be no combinational path from any input to any output except in_ready from hold_full.
REQ-024 Lanes SHALL be emitted lane 0 first, on consecutive cycles, with no bubbles inside a word.
REQ-025 Latency SHALL be as follows:
- Bypass: lane 0 appears the cycle after the handshake edge.
- Otherwise: lane 0 appears the cycle after the next boundary edge, at most DIV+1 cycles after the handshake.
REQ-026 Back-to-back words SHALL stream with zero gap when in_valid is held high; sustained throughput SHALL be one word per DIV cycles.
REQ-027 calib=1 on an edge SHALL set phase<=0 and active<=0 and SHALL abort the in-flight word, with no load and no gap_cnt increment. hold and hold_full SHALL be retained, and handshakes into hold SHALL remain allowed.
REQ-028 While calib is held high, phase SHALL stay 0 and no boundary SHALL occur. The first boundary after release SHALL be DIV cycles after the last calib edge.
REQ-029 If calib and a boundary coincide, calib SHALL win: no load, hold_full unchanged, and a bypass handshake goes into hold instead.

Reset
REQ-030 When resetn=0 on an edge, the block SHALL set: phase=0, hold_full=0, active=0, gap_cnt=0, first-word flag=0, shift=0, hold=0.
REQ-031 During reset, out_data=0, out_valid=0, word_start=0 and in_ready=1 from the first cycle after the reset edge.
REQ-032 Reset SHALL have priority over calib and handshakes; an in-flight word SHALL be discarded.

Verification (W=8, DIV=5)
REQ-033 Reset, then word 0x5544332211 offered at phase 2 -> in_ready drops next cycle. After the phase-4 edge, out_data = 11,22,33,44,55 with word_start on 11, then out_valid=0, and gap_cnt increments to 1 at the following boundary.
REQ-034 in_valid held high with words A,B,C -> 15 contiguous valid lanes; word_start every 5th cycle; gap_cnt stays 0.
REQ-035 Word offered exactly at phase 4 with hold empty -> bypass; lane 0 appears the next cycle at phase 0.
REQ-036 calib pulsed at phase 2 of word A while word B is in hold -> lanes 3,4 of A are dropped. phase restarts at 0 and B begins 5 cycles after the calib edge; gap_cnt is unchanged.
REQ-037 resetn pulsed low mid-word with hold full -> all outputs 0 and in_ready=1 next cycle; subsequent words are unaffected.
REQ-038 No input for 70000 boundaries after one word -> gap_cnt saturates at 16'hFFFF.

Source files
------------

// File: rtl/ddr3_gearbox_ser.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// ddr3_gearbox_ser
//
// Serialises one DIV*W-bit parallel word into DIV consecutive W-bit lanes,
// lane 0 first. Everything runs on the fast clock. A free-running slot
// counter (phase) marks the slot boundary, which is the edge where
// phase == DIV-1. A word can only begin on a boundary, so every word is
// aligned to the slow-clock frame.
//
// Storage is two stages:
//   hold  / hold_full : one-word skid buffer that is written off-boundary
//   shift / active    : the word that is being emitted
// A word offered exactly on a boundary with an empty hold bypasses it and
// goes straight into shift.
//
// Ports
//   hclkin      fast clock; all logic uses the rising edge
//   resetn      synchronous active-low reset
//   calib       synchronous slot realign: restarts phase and aborts the
//               word in flight; hold is kept
//   in_data     parallel word; lane k is bits [k*W +: W]
//   in_valid    in_data is valid
//   in_ready    a word can be accepted this cycle (= !hold_full)
//   out_data    serial lane; 0 when no word is active
//   out_valid   out_data carries a real lane
//   word_start  out_data is lane 0 of a word
//   phase       current slot index, 0..DIV-1
//   gap_cnt     idle boundaries since the first accepted word; saturates
// ---------------------------------------------------------------------------
module ddr3_gearbox_ser #(
    parameter int W   = 8,   // lane width, 1..32
    parameter int DIV = 5    // lanes per word, 2..8
) (
    input  logic             hclkin,
    input  logic             resetn,
    input  logic             calib,
    input  logic [DIV*W-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [W-1:0]     out_data,
    output logic             out_valid,
    output logic             word_start,
    output logic [2:0]       phase,
    output logic [15:0]      gap_cnt
);

    localparam logic [2:0] LAST_SLOT = 3'(DIV - 1);

    logic [2:0]       phase_q;
    logic [DIV*W-1:0] hold;
    logic             hold_full;
    logic [DIV*W-1:0] shift;
    logic             active;
    logic [15:0]      gap_q;
    logic             seen;      // a word has been accepted since reset

    logic boundary;
    logic handshake;

    // Saturating increment for the idle-boundary counter.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        if (v == 16'hFFFF)
            sat_inc16 = v;
        else
            sat_inc16 = v + 16'd1;
    endfunction

    // Next slot index, wrapping after the boundary slot.
    function automatic logic [2:0] next_slot(input logic [2:0] p);
        if (p == LAST_SLOT)
            next_slot = 3'd0;
        else
            next_slot = p + 3'd1;
    endfunction

    assign boundary  = (phase_q == LAST_SLOT);
    assign handshake = in_valid && !hold_full;

    always_ff @(posedge hclkin) begin
        if (!resetn) begin
            phase_q   <= 3'd0;
            hold      <= '0;
            hold_full <= 1'b0;
            shift     <= '0;
            active    <= 1'b0;
            gap_q     <= 16'd0;
            seen      <= 1'b0;
        end else if (calib) begin
            // Realign: the word in flight is dropped and no boundary is
            // taken on this edge. Any word (including one that would have
            // bypassed) lands in hold and waits for the next boundary.
            phase_q <= 3'd0;
            active  <= 1'b0;
            if (handshake) begin
                hold      <= in_data;
                hold_full <= 1'b1;
                seen      <= 1'b1;
            end
        end else begin
            phase_q <= next_slot(phase_q);
            if (boundary) begin
                // ---- boundary: hold -> shift stage ----
                if (hold_full) begin
                    // in_ready is low here, so no new word can arrive.
                    shift     <= hold;
                    active    <= 1'b1;
                    hold_full <= 1'b0;
                end else if (handshake) begin
                    // Bypass: the new word goes straight out next cycle.
                    shift  <= in_data;
                    active <= 1'b1;
                    seen   <= 1'b1;
                end else begin
                    active <= 1'b0;
                    if (seen)
                        gap_q <= sat_inc16(gap_q);
                end
            end else begin
                // ---- mid-word: emit next lane, accept into hold ----
                // Shifting right keeps the current lane in the low bits,
                // so the output needs no phase-indexed mux.
                if (active)
                    shift <= shift >> W;
                if (handshake) begin
                    hold      <= in_data;
                    hold_full <= 1'b1;
                    seen      <= 1'b1;
                end
            end
        end
    end

    // Outputs depend only on state; in_ready is the sole path from hold_full.
    assign in_ready   = !hold_full;
    assign out_data   = active ? shift[W-1:0] : '0;
    assign out_valid  = active;
    assign word_start = active && (phase_q == 3'd0);
    assign phase      = phase_q;
    assign gap_cnt    = gap_q;

endmodule

// File: tb/tb_ddr3_gearbox_ser.sv
`timescale 1ns/1ps
module tb_ddr3_gearbox_ser;

    localparam int W   = 8;
    localparam int DIV = 5;

    logic             hclkin = 1'b0;
    logic             resetn;
    logic             calib;
    logic [DIV*W-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     out_data;
    logic             out_valid;
    logic             word_start;
    logic [2:0]       phase;
    logic [15:0]      gap_cnt;

    always #5 hclkin = ~hclkin;

    ddr3_gearbox_ser #(.W(W), .DIV(DIV)) u_dut (
        .hclkin     (hclkin),
        .resetn     (resetn),
        .calib      (calib),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .word_start (word_start),
        .phase      (phase),
        .gap_cnt    (gap_cnt)
    );

    typedef struct packed {
        logic [7:0] d;
        logic       ws;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   run_len  = 0;
    int   run_max  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Output monitor: compares every emitted lane against the scoreboard.
    always @(negedge hclkin) begin
        exp_t e;
        if (out_valid === 1'b1) begin
            run_len++;
            if (run_len > run_max) run_max = run_len;
            if (sb.size() == 0) begin
                chk("unexp_lane", 64'(out_valid), 64'd0);
            end else begin
                e = sb.pop_front();
                chk("lane_data", 64'(out_data), 64'(e.d));
                chk("lane_ws", 64'(word_start), 64'(e.ws));
            end
        end else begin
            run_len = 0;
            if (resetn === 1'b1 || resetn === 1'b0)
                chk("idle_out", 64'({word_start, out_data}), 64'd0);
        end
    end

    // Main thread always sits 1 time unit after a falling edge.
    task automatic tick();
        @(negedge hclkin);
        #1;
    endtask

    task automatic do_reset();
        resetn   = 1'b0;
        calib    = 1'b0;
        in_valid = 1'b0;
        tick();
        sb.delete();
        resetn  = 1'b1;
        run_max = 0;
    endtask

    task automatic wait_phase(input logic [2:0] p);
        int n = 0;
        while (phase !== p && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) chk("wait_phase_timeout", 64'(phase), 64'(p));
    endtask

    task automatic send(input logic [39:0] w, input int nl);
        int n = 0;
        in_data  = w;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) begin
            chk("send_timeout", 64'(in_ready), 64'd1);
        end else begin
            for (int k = 0; k < nl; k++)
                sb.push_back(exp_t'{d: w[k*8 +: 8], ws: (k == 0)});
        end
        tick();
    endtask

    task automatic wait_empty();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) chk("drain_timeout", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        resetn   = 1'b0;
        calib    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        tick();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_word_start", 64'(word_start), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_phase", 64'(phase), 64'd0);
        chk("rst_gap", 64'(gap_cnt), 64'd0);
        tick();
        resetn = 1'b1;

        // Single word offered at phase 2, goes through hold.
        wait_phase(3'd2);
        send(40'h5544332211, 5);
        in_valid = 1'b0;
        chk("t1_in_ready_drop", 64'(in_ready), 64'd0);
        chk("t1_phase3", 64'(phase), 64'd3);
        chk("t1_not_yet", 64'(out_valid), 64'd0);
        tick();
        chk("t1_phase4_idle", 64'(out_valid), 64'd0);
        tick();
        chk("t1_lane0_valid", 64'(out_valid), 64'd1);
        chk("t1_lane0_phase", 64'(phase), 64'd0);
        wait_empty();
        chk("t1_gap_before", 64'(gap_cnt), 64'd0);
        tick();
        chk("t1_after_valid", 64'(out_valid), 64'd0);
        chk("t1_gap1", 64'(gap_cnt), 64'd1);
        for (int i = 0; i < 2*DIV; i++) tick();
        chk("t1_gap3", 64'(gap_cnt), 64'd3);

        // Back-to-back stream of three words.
        do_reset();
        send(40'hA4A3A2A1A0, 5);
        send(40'hB4B3B2B1B0, 5);
        send(40'hC4C3C2C1C0, 5);
        in_valid = 1'b0;
        wait_empty();
        chk("t2_contiguous", 64'(run_max), 64'd15);
        chk("t2_gap", 64'(gap_cnt), 64'd0);

        // Bypass on a boundary with hold empty.
        do_reset();
        wait_phase(3'd4);
        chk("t3_ready_at_bnd", 64'(in_ready), 64'd1);
        send(40'h0F0E0D0C0B, 5);
        in_valid = 1'b0;
        chk("t3_bypass_valid", 64'(out_valid), 64'd1);
        chk("t3_bypass_ws", 64'(word_start), 64'd1);
        chk("t3_bypass_phase", 64'(phase), 64'd0);
        chk("t3_hold_empty", 64'(in_ready), 64'd1);
        wait_empty();

        // Calib pulse at phase 2 of A while B sits in hold.
        do_reset();
        wait_phase(3'd4);
        send(40'h1514131211, 3);
        send(40'h2524232221, 5);
        in_valid = 1'b0;
        tick();
        chk("t4_phase2", 64'(phase), 64'd2);
        calib = 1'b1;
        tick();
        calib = 1'b0;
        chk("t4_cal_phase", 64'(phase), 64'd0);
        chk("t4_cal_abort", 64'(out_valid), 64'd0);
        chk("t4_hold_kept", 64'(in_ready), 64'd0);
        chk("t4_cal_gap", 64'(gap_cnt), 64'd0);
        for (int i = 0; i < DIV-1; i++) tick();
        chk("t4_pre_b_phase", 64'(phase), 64'd4);
        chk("t4_pre_b_idle", 64'(out_valid), 64'd0);
        tick();
        chk("t4_b_start", 64'(word_start), 64'd1);
        wait_empty();
        chk("t4_gap_unchanged", 64'(gap_cnt), 64'd0);

        // Calib held high: phase frozen, boundary DIV cycles after release.
        tick();
        chk("t5_gap_idle", 64'(gap_cnt), 64'd1);
        calib = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t5_phase_held", 64'(phase), 64'd0);
        end
        calib = 1'b0;
        for (int i = 0; i < DIV-1; i++) tick();
        chk("t5_phase4", 64'(phase), 64'd4);
        chk("t5_gap_held", 64'(gap_cnt), 64'd1);
        tick();
        chk("t5_phase_wrap", 64'(phase), 64'd0);
        chk("t5_gap2", 64'(gap_cnt), 64'd2);

        // Calib on a boundary: would-be bypass lands in hold instead.
        do_reset();
        wait_phase(3'd4);
        calib = 1'b1;
        send(40'h3534333231, 5);
        calib    = 1'b0;
        in_valid = 1'b0;
        chk("t6_no_load", 64'(out_valid), 64'd0);
        chk("t6_in_hold", 64'(in_ready), 64'd0);
        chk("t6_phase", 64'(phase), 64'd0);
        for (int i = 0; i < DIV-1; i++) tick();
        chk("t6_wait", 64'(out_valid), 64'd0);
        tick();
        chk("t6_start", 64'(word_start), 64'd1);
        wait_empty();

        // Reset mid-word with hold full.
        do_reset();
        wait_phase(3'd4);
        send(40'h4544434241, 2);
        send(40'h5554535251, 0);
        in_valid = 1'b0;
        chk("t7_lanes_seen", 64'(sb.size()), 64'd0);
        chk("t7_hold_full", 64'(in_ready), 64'd0);
        resetn = 1'b0;
        tick();
        chk("t7_rst_valid", 64'(out_valid), 64'd0);
        chk("t7_rst_data", 64'(out_data), 64'd0);
        chk("t7_rst_ws", 64'(word_start), 64'd0);
        chk("t7_rst_ready", 64'(in_ready), 64'd1);
        chk("t7_rst_phase", 64'(phase), 64'd0);
        resetn = 1'b1;
        wait_phase(3'd2);
        send(40'h6564636261, 5);
        in_valid = 1'b0;
        wait_empty();

        // Gap counter saturation, starting just below the ceiling.
        do_reset();
        send(40'h7574737271, 5);
        in_valid = 1'b0;
        wait_empty();
        tick();
        chk("t8_gap1", 64'(gap_cnt), 64'd1);
        chk("t8_phase0", 64'(phase), 64'd0);
        force u_dut.gap_q = 16'hFFFD;
        #1;
        release u_dut.gap_q;
        for (int i = 0; i < DIV; i++) tick();
        chk("t8_gap_fffe", 64'(gap_cnt), 64'hFFFE);
        for (int i = 0; i < DIV; i++) tick();
        chk("t8_gap_ffff", 64'(gap_cnt), 64'hFFFF);
        for (int i = 0; i < 2*DIV; i++) tick();
        chk("t8_gap_sat", 64'(gap_cnt), 64'hFFFF);

        chk("final_sb_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
